prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Bus-master sequencer that owns the SAP-1 bus while the CPU is stopped. It loads a program
//  into the 16-byte RAM over a valid/ready byte stream, pulses the CPU reset, lets the CPU run
//  until it halts, and reports the run length in clock cycles.
//  It sits beside the machine and drives the external-bus select, the memory-address-register
//  write strobe and the memory write strobe.
// PARAMETERS
//  ADDR_W  4   RAM address width; RAM depth is 2**ADDR_W
//  DATA_W  8   bus / byte width
//  CYC_W   16  width of the run-cycle counter
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  start        in   1       begin load+run; sampled only in IDLE
//  abort        in   1       return to IDLE from any state next cycle
//  load_len     in   ADDR_W  bytes to load, sampled with start; 0 means 2**ADDR_W
//  in_valid     in   1       byte-stream valid
//  in_data      in   DATA_W  byte-stream data
//  in_ready     out  1       byte-stream ready
//  cpu_halted   in   1       halt flag from the CPU control word
//  bus_drive    out  1       external-bus select into the machine
//  bus_value    out  DATA_W  value driven onto the bus when bus_drive=1, otherwise 0
//  wr_mem_adr   out  1       memory address register write strobe
//  wr_mem       out  1       RAM data write strobe
//  cpu_reset    out  1       CPU reset
//  cpu_run      out  1       CPU clock enable
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse on halt detection
//  cycles       out  CYC_W   CPU run cycles of the last run, saturating
// BEHAVIOUR
//  reset: state=IDLE, addr=0, cycles=0; all strobes, in_ready, cpu_run and done are 0.
//   cpu_reset=1 while reset is asserted.
//  States: IDLE, SET_ADR, LOAD, CPU_RST, RUN, DONE. Outputs are decoded from the state.
//   wr_mem is decoded from the state ANDed with the handshake.
//  IDLE: cpu_run=0.
//   On start: latch len (0 maps to 2**ADDR_W), set addr=0, clear cycles, go to SET_ADR.
//  SET_ADR (one cycle): bus_drive=1, bus_value={0,addr}, wr_mem_adr=1, then go to LOAD.
//  LOAD: in_ready=1. When in_valid & in_ready, in the same cycle:
//   - bus_drive=1, bus_value=in_data, wr_mem=1;
//   - addr <= addr+1.
//   If addr==len-1, go to CPU_RST; otherwise go to SET_ADR.
//   Each byte therefore costs at least 2 cycles. If in_valid is low, stay in LOAD and drive nothing.
//  CPU_RST (one cycle): cpu_reset=1, then go to RUN.
//  RUN: cpu_run=1. cycles increments every cycle and saturates at all-ones, with no wrap.
//   When cpu_halted=1, go to DONE; that cycle is counted.
//  DONE (one cycle): done=1, cpu_run=0, then go to IDLE. cycles holds until the next start.
//  abort has priority over every transition: next state is IDLE and cpu_run drops.
//   RAM contents already written remain; cycles holds its value.
//  start outside IDLE is ignored. The addr counter is ADDR_W+1 bits internally, so len=16 needs no wrap.
//  reset mid-load or mid-run: immediate return to the reset values in the next cycle.
//  Mutual exclusion: wr_mem_adr and wr_mem are never high together. bus_drive=1 only in SET_ADR
//   and in LOAD with a handshake.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE..S_DONE) and the DEFAULT_ADDR_W/DATA_W constants.
//  One sub-module: sat_counter #(W) with clk, reset, clr, en and q; used for cycles.
//  The FSM, addr counter and output decode stay in this module.
// TESTING
//  1) start, load_len=3, bytes 0x1E,0x2F,0xE0 sent back-to-back ->
//     wr_mem_adr sees bus 0,1,2; wr_mem sees 0x1E,0x2F,0xE0; one cpu_reset pulse follows.
//  2) load_len=0 -> exactly 16 wr_mem pulses at addr 0..15, then CPU_RST.
//  3) in_valid gaps of 0-3 random cycles -> no write without a handshake; data order preserved.
//  4) Model cpu_halted asserted on the 7th RUN cycle -> cycles=7, done high for exactly 1 cycle, busy=0 next.
//  5) CYC_W=4, cpu_halted never asserted for 20 cycles, then asserted -> cycles=15 (saturated).
//  6) abort during LOAD after 2 bytes, then reset asserted during RUN ->
//     IDLE next cycle with cpu_run=0; after reset, cycles=0 and cpu_reset=1 while reset is held.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg
//   Shared constants and state encoding for the SAP-1 program loader.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CYC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_ADR = 3'd1,
    S_LOAD    = 3'd2,
    S_CPU_RST = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage : prog_loader_pkg

`default_nettype wire

// File: rtl/prog_loader_sat.sv
// ============================================================================
// sat_counter
//   Up counter with synchronous clear that sticks at all-ones instead of wrapping.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] C_ONE = W'(1);
  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
//   Bus-master sequencer: streams a program into SAP-1 RAM, resets the CPU,
//   runs it until halt and reports the run length in cycles.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CYC_W  = DEFAULT_CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] load_len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              cpu_halted_i,
  output logic              bus_drive_o,
  output logic [DATA_W-1:0] bus_value_o,
  output logic              wr_mem_adr_o,
  output logic              wr_mem_o,
  output logic              cpu_reset_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CYC_W-1:0]  cycles_o
);

  // One extra address bit so a full-depth load (len = 2**ADDR_W) ends without wrapping.
  localparam logic [ADDR_W:0] C_FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q;
  state_e          state_d;
  logic [ADDR_W:0] addr_q;
  logic [ADDR_W:0] addr_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_d;

  logic w_hs;
  logic w_last;
  logic w_take_start;
  logic w_cnt_en;

  assign w_hs         = (state_q == S_LOAD) && in_valid_i;
  assign w_last       = (addr_q == (len_q - C_ONE));
  assign w_take_start = (state_q == S_IDLE) && start_i && !abort_i;
  assign w_cnt_en     = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_take_start) begin
          len_d   = (load_len_i == '0) ? C_FULL_LEN : {1'b0, load_len_i};
          addr_d  = '0;
          state_d = S_SET_ADR;
        end
      end
      S_SET_ADR: state_d = S_LOAD;
      S_LOAD: begin
        if (w_hs) begin
          addr_d  = addr_q + C_ONE;
          state_d = w_last ? S_CPU_RST : S_SET_ADR;
        end
      end
      S_CPU_RST: state_d = S_RUN;
      S_RUN: begin
        if (cpu_halted_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  sat_counter #(
    .W (CYC_W)
  ) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr_i (w_take_start),
    .en_i  (w_cnt_en),
    .q_o   (cycles_o)
  );

  // Outputs are forced quiet while reset is held so the bus is released immediately.
  always_comb begin
    bus_drive_o  = 1'b0;
    bus_value_o  = '0;
    wr_mem_adr_o = 1'b0;
    wr_mem_o     = 1'b0;
    in_ready_o   = 1'b0;
    cpu_reset_o  = reset;
    cpu_run_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    if (!reset) begin
      busy_o = (state_q != S_IDLE);
      unique case (state_q)
        S_SET_ADR: begin
          bus_drive_o  = 1'b1;
          bus_value_o  = {{(DATA_W-ADDR_W){1'b0}}, addr_q[ADDR_W-1:0]};
          wr_mem_adr_o = 1'b1;
        end
        S_LOAD: begin
          in_ready_o = 1'b1;
          if (w_hs) begin
            bus_drive_o = 1'b1;
            bus_value_o = in_data_i;
            wr_mem_o    = 1'b1;
          end
        end
        S_CPU_RST: cpu_reset_o = 1'b1;
        S_RUN:     cpu_run_o   = 1'b1;
        S_DONE:    done_o      = 1'b1;
        default: ;
      endcase
    end
  end

endmodule : prog_loader

`default_nettype wire
